// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART receiver.
package uart_pkg;

    localparam int unsigned MAX_DATA_WIDTH = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // Layout puts the flags in the LSBs so the low DATA_WIDTH+2 bits form the FIFO word.
    typedef struct packed {
        logic [MAX_DATA_WIDTH-1:0] data;
        logic                      perr;
        logic                      ferr;
    } rx_word_t;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO with registered head, valid, full, empty and count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_n;
    logic [CW-1:0]    count_n;
    logic [CW-1:0]    remain_c;
    logic             do_pop_c;
    logic             do_push_c;

    assign do_pop_c  = pop & valid;
    assign do_push_c = push & (~full | do_pop_c);

    always_comb begin
        rd_ptr_n = rd_ptr + AW'(do_pop_c);
        remain_c = count - CW'(do_pop_c);
        count_n  = remain_c + CW'(do_push_c);
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= wdata;
    end

    // Head only shows entries written on an earlier cycle, so a push into an empty FIFO appears a clk later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            rdata  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            valid  <= (remain_c != '0);
            if (remain_c != '0) rdata <= mem[rd_ptr_n];
            full   <= (count_n == CW'(DEPTH));
            empty  <= (count_n == '0);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled, majority-voted UART receiver feeding a FWFT FIFO read over valid/ready.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rx_sig,
    input  logic                          m_ready,
    output logic                          m_valid,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_parity_err,
    output logic                          m_frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun
);
    localparam int unsigned DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
    localparam int unsigned FW    = DATA_WIDTH + 2;
    localparam logic [OS_W-1:0] SMP0      = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] SMP1      = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] SMP2      = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0] LAST_TICK = OS_W'(OVERSAMPLE - 1);
    localparam parity_e PAR_MODE = parity_e'(2'(PARITY));

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_fifo: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_os
        $error("uart_rx_fifo: OVERSAMPLE must be even and >= 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
    end

    rx_state_e             state;
    logic                  rx_meta, rxs, rxs_d;
    logic [DIV_W-1:0]      div_cnt;
    logic [OS_W-1:0]       tick_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  smp0, smp1;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  perr, ferr, push_q;
    logic                  start_edge_c, tick_c, bit_v_c, fifo_pop_c;
    logic                  fifo_full, fifo_empty;
    logic [FW-1:0]         fifo_rdata;
    rx_word_t              wr_word;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx_sig;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign start_edge_c = rxs_d & ~rxs;
    assign tick_c       = (div_cnt == '0);
    assign bit_v_c      = vote3(smp0, smp1, rxs);

    // Restarting at 0 on the start edge makes the first tick of the frame land on the next clk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                    div_cnt <= '0;
        else if (state == ST_IDLE && start_edge_c)    div_cnt <= '0;
        else if (tick_c)                              div_cnt <= DIV_W'(DIV - 1);
        else                                          div_cnt <= div_cnt - DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            smp0     <= 1'b1;
            smp1     <= 1'b1;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            push_q   <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (state == ST_IDLE) begin
                if (start_edge_c) begin
                    state    <= ST_START;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    perr     <= 1'b0;
                    ferr     <= 1'b0;
                end
            end else if (tick_c) begin
                tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + OS_W'(1);
                if (tick_cnt == SMP0) smp0 <= rxs;
                if (tick_cnt == SMP1) smp1 <= rxs;
                case (state)
                    ST_START: begin
                        if (tick_cnt == SMP2 && bit_v_c) state <= ST_IDLE;
                        else if (tick_cnt == LAST_TICK)  state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (tick_cnt == SMP2) shreg <= {bit_v_c, shreg[DATA_WIDTH-1:1]};
                        if (tick_cnt == LAST_TICK) begin
                            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                                bit_cnt <= '0;
                                state   <= (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (tick_cnt == SMP2) perr <= (((^shreg) ^ bit_v_c) != (PAR_MODE == PAR_ODD));
                        if (tick_cnt == LAST_TICK) state <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Leave on the last stop vote so a back-to-back start edge is never missed.
                        if (tick_cnt == SMP2) begin
                            if (!bit_v_c) ferr <= 1'b1;
                            if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                                push_q <= 1'b1;
                                state  <= ST_IDLE;
                            end
                        end else if (tick_cnt == LAST_TICK) begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        wr_word      = '0;
        wr_word.data = MAX_DATA_WIDTH'(shreg);
        wr_word.perr = perr;
        wr_word.ferr = ferr;
    end

    assign fifo_pop_c = m_ready & ~fifo_empty;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_q),
        .wdata (FW'(wr_word)),
        .pop   (fifo_pop_c),
        .rdata (fifo_rdata),
        .valid (m_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_data       = fifo_rdata[FW-1:2];
    assign m_parity_err = fifo_rdata[1];
    assign m_frame_err  = fifo_rdata[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) overrun <= 1'b0;
        else       overrun <= push_q & fifo_full & ~(m_valid & m_ready);
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance, clocked for a 4-clk tick.
module tb_uart_rx_fifo;
    localparam int unsigned CLK_HZ   = 7_372_800;
    localparam int          BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx_a, rx_b, rdy_a, rdy_b;
    logic       val_a, val_b, pe_a, pe_b, fe_a, fe_b, ov_a, ov_b;
    logic [7:0] d_a, d_b;
    logic [4:0] cnt_a, cnt_b;

    int n_tests = 0;
    int n_fail  = 0;
    int ov_cnt_a = 0;
    int rd_a = 0;
    int rd_b = 0;
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_WIDTH(8), .BAUD_RATE(115200), .CLK_FREQ(CLK_HZ), .OVERSAMPLE(16),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_dut_a (
        .clk(clk), .rstn(rstn), .rx_sig(rx_a), .m_ready(rdy_a), .m_valid(val_a),
        .m_data(d_a), .m_parity_err(pe_a), .m_frame_err(fe_a), .fifo_count(cnt_a), .overrun(ov_a)
    );

    uart_rx_fifo #(
        .DATA_WIDTH(8), .BAUD_RATE(115200), .CLK_FREQ(CLK_HZ), .OVERSAMPLE(16),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_dut_b (
        .clk(clk), .rstn(rstn), .rx_sig(rx_b), .m_ready(rdy_b), .m_valid(val_b),
        .m_data(d_b), .m_parity_err(pe_b), .m_frame_err(fe_b), .fifo_count(cnt_b), .overrun(ov_b)
    );

    // Accepted beats captured as {perr, ferr, data}.
    always @(negedge clk) begin
        if (rstn && val_a && rdy_a) q_a.push_back({pe_a, fe_a, d_a});
        if (rstn && val_b && rdy_b) q_b.push_back({pe_b, fe_b, d_b});
        if (rstn && ov_a) ov_cnt_a++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) rx_b = v;
        else       rx_a = v;
    endtask

    task automatic send_frame(input bit which, input logic [7:0] data, input int bclk,
                              input bit has_par, input logic par_bit, input logic stop_v);
        set_rx(which, 1'b0);
        step(bclk);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, data[i]);
            step(bclk);
        end
        if (has_par) begin
            set_rx(which, par_bit);
            step(bclk);
        end
        set_rx(which, stop_v);
        step(bclk);
        set_rx(which, 1'b1);
    endtask

    task automatic expect_beat(input bit which, input logic [9:0] exp, input string tag);
        int waited = 0;
        if (which) begin
            while (q_b.size() <= rd_b && waited < 2000) begin step(1); waited++; end
            check({tag, "_avail"}, 32'(q_b.size() > rd_b), 32'd1);
            if (q_b.size() > rd_b) begin
                check(tag, 32'(q_b[rd_b]), 32'(exp));
                rd_b++;
            end
        end else begin
            while (q_a.size() <= rd_a && waited < 2000) begin step(1); waited++; end
            check({tag, "_avail"}, 32'(q_a.size() > rd_a), 32'd1);
            if (q_a.size() > rd_a) begin
                check(tag, 32'(q_a[rd_a]), 32'(exp));
                rd_a++;
            end
        end
    endtask

    initial begin
        int ov_base;
        rstn  = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        step(5);
        check("rst_valid", 32'(val_a), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_data",  32'(d_a),   32'd0);
        check("rst_ovr",   32'(ov_a),  32'd0);
        rstn = 1'b1;
        step(10);

        // Plain 8N1 word, single beat with ready held high
        send_frame(1'b0, 8'hA5, BIT_CLKS, 1'b0, 1'b0, 1'b1);
        expect_beat(1'b0, {2'b00, 8'hA5}, "a5");
        step(20);
        check("a5_one_beat", 32'(q_a.size()), 32'(rd_a));
        check("a5_valid_low", 32'(val_a), 32'd0);

        // Even parity: 0x3C has four ones, 0x07 has three
        send_frame(1'b1, 8'h3C, BIT_CLKS, 1'b1, 1'b1, 1'b1);
        expect_beat(1'b1, {2'b10, 8'h3C}, "par3c_bad");
        send_frame(1'b1, 8'h3C, BIT_CLKS, 1'b1, 1'b0, 1'b1);
        expect_beat(1'b1, {2'b00, 8'h3C}, "par3c_good");
        send_frame(1'b1, 8'h07, BIT_CLKS, 1'b1, 1'b1, 1'b1);
        expect_beat(1'b1, {2'b00, 8'h07}, "par07_good");
        send_frame(1'b1, 8'h07, BIT_CLKS, 1'b1, 1'b0, 1'b1);
        expect_beat(1'b1, {2'b10, 8'h07}, "par07_bad");

        // Start-bit glitch of 3 ticks stores nothing
        rx_a = 1'b0;
        step(12);
        rx_a = 1'b1;
        step(BIT_CLKS * 12);
        check("glitch_count", 32'(cnt_a), 32'd0);
        check("glitch_nobeat", 32'(q_a.size()), 32'(rd_a));
        send_frame(1'b0, 8'h5A, BIT_CLKS, 1'b0, 1'b0, 1'b1);
        expect_beat(1'b0, {2'b00, 8'h5A}, "post_glitch");

        // Stop bit low gives a frame error, next frame is clean
        send_frame(1'b0, 8'h55, BIT_CLKS, 1'b0, 1'b0, 1'b0);
        expect_beat(1'b0, {2'b01, 8'h55}, "ferr55");
        step(BIT_CLKS * 2);
        send_frame(1'b0, 8'hC3, BIT_CLKS, 1'b0, 1'b0, 1'b1);
        expect_beat(1'b0, {2'b00, 8'hC3}, "post_ferr");

        // Fill past capacity with ready low, then drain in order
        rdy_a   = 1'b0;
        ov_base = ov_cnt_a;
        for (int i = 0; i < 17; i++) send_frame(1'b0, 8'(i), BIT_CLKS, 1'b0, 1'b0, 1'b1);
        step(100);
        check("full_count", 32'(cnt_a), 32'd16);
        check("overrun_pulses", 32'(ov_cnt_a - ov_base), 32'd1);
        check("full_valid", 32'(val_a), 32'd1);
        check("full_head", 32'(d_a), 32'h00);
        rdy_a = 1'b1;
        for (int i = 0; i < 16; i++) expect_beat(1'b0, {2'b00, 8'(i)}, "drain");
        step(5);
        check("drained_count", 32'(cnt_a), 32'd0);
        check("no_extra_beat", 32'(q_a.size()), 32'(rd_a));

        // Baud skew of about -3% and +3%
        for (int i = 0; i < 4; i++) send_frame(1'b0, (i % 2 == 0) ? 8'hFF : 8'h00, 62, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) expect_beat(1'b0, {2'b00, (i % 2 == 0) ? 8'hFF : 8'h00}, "skew_fast");
        for (int i = 0; i < 4; i++) send_frame(1'b0, (i % 2 == 0) ? 8'hFF : 8'h00, 66, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) expect_beat(1'b0, {2'b00, (i % 2 == 0) ? 8'hFF : 8'h00}, "skew_slow");

        // Reset mid-DATA clears a buffered word and the partial frame
        rdy_a = 1'b0;
        send_frame(1'b0, 8'h42, BIT_CLKS, 1'b0, 1'b0, 1'b1);
        step(20);
        check("pre_rst_valid", 32'(val_a), 32'd1);
        rx_a = 1'b0; step(BIT_CLKS);
        rx_a = 1'b1; step(BIT_CLKS);
        rx_a = 1'b0; step(BIT_CLKS);
        rx_a = 1'b0; step(BIT_CLKS / 2);
        rstn = 1'b0;
        step(2);
        check("midrst_valid", 32'(val_a), 32'd0);
        check("midrst_count", 32'(cnt_a), 32'd0);
        check("midrst_data",  32'(d_a),   32'd0);
        rx_a = 1'b1;
        step(5);
        rstn = 1'b1;
        step(20);
        rdy_a = 1'b1;
        step(5);
        check("midrst_nobeat", 32'(q_a.size()), 32'(rd_a));
        send_frame(1'b0, 8'h81, BIT_CLKS, 1'b0, 1'b0, 1'b1);
        expect_beat(1'b0, {2'b00, 8'h81}, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
